// File: rtl/spi_apb_arb.sv
// -----------------------------------------------------------------------------
// spi_apb_arb
//
// Round-robin APB arbiter. It shares one spi_apb slave port between N_M
// upstream APB masters, such as a CPU and a DMA engine. Each granted
// transaction is re-issued downstream as a clean SETUP/ACCESS pair. The
// response is then routed back to the master that owns the transfer.
//
// Optional feature: define SPI_APB_ARB_LOCK_EN to add the m_lock input.
//   - A master that completes a transfer with m_lock set keeps exclusive
//     ownership. This keeps SPI CS/command sequences atomic.
//   - The lock is released when that master completes a transfer with
//     m_lock low, or when it is idle in IDLE with both m_lock and m_psel low.
//   - Without the macro, every IDLE cycle re-arbitrates.
//
// Parameters
//   N_M  number of upstream masters (2..8)
//   AW   APB address width
//   DW   APB data width
//
// Ports
//   pclk, presetn          clock, asynchronous active-low reset
//   m_paddr/m_pwdata       packed per-master address / write data (i*AW, i*DW)
//   m_psel/m_penable/m_pwrite  per-master APB control
//   m_lock                 per-master lock request (SPI_APB_ARB_LOCK_EN only)
//   m_prdata/m_pready/m_pslverr  per-master response, only the owner sees it
//   s_*                    downstream APB port towards spi_apb
//   grant                  one-hot owner of the downstream transfer, 0 in IDLE
//   busy                   downstream transfer in flight
// -----------------------------------------------------------------------------
module spi_apb_arb #(
    parameter int N_M = 2,
    parameter int AW  = 5,
    parameter int DW  = 32
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [N_M*AW-1:0] m_paddr,
    input  logic [N_M*DW-1:0] m_pwdata,
    input  logic [N_M-1:0]    m_psel,
    input  logic [N_M-1:0]    m_penable,
    input  logic [N_M-1:0]    m_pwrite,
`ifdef SPI_APB_ARB_LOCK_EN
    input  logic [N_M-1:0]    m_lock,
`endif
    output logic [N_M*DW-1:0] m_prdata,
    output logic [N_M-1:0]    m_pready,
    output logic [N_M-1:0]    m_pslverr,
    output logic [AW-1:0]     s_paddr,
    output logic [DW-1:0]     s_pwdata,
    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    input  logic [DW-1:0]     s_prdata,
    input  logic              s_pready,
    input  logic              s_pslverr,
    output logic [N_M-1:0]    grant,
    output logic              busy
);

    localparam int LW = (N_M > 1) ? $clog2(N_M) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state, state_nx;
    logic [LW-1:0] last;      // previous owner; the scan starts just after it
    logic [LW-1:0] gidx;      // index of the current owner
    logic [LW-1:0] pick;
    logic [N_M-1:0] req;
    logic          req_any;
    logic          done;

    // First requester after lst, wrapping modulo N_M. lst itself is checked last.
    function automatic logic [LW-1:0] rr_pick(input logic [N_M-1:0] r,
                                              input logic [LW-1:0]  lst);
        logic [LW-1:0] sel;
        logic          hit;
        int            idx;
        sel = '0;
        hit = 1'b0;
        for (int k = 1; k <= N_M; k++) begin
            idx = (int'(lst) + k) % N_M;
            if (!hit && r[idx]) begin
                sel = LW'(idx);
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

`ifdef SPI_APB_ARB_LOCK_EN
    logic lock_act;
    logic lock_hold;

    // last is the owner of the most recent transfer, so it is also the lock holder.
    assign lock_hold = lock_act & (m_lock[last] | m_psel[last]);

    always_comb begin
        req = m_psel;
        if (lock_hold) begin
            req       = '0;
            req[last] = m_psel[last];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            lock_act <= 1'b0;
        end else if (done) begin
            lock_act <= m_lock[gidx];
        end else if (state == IDLE && !lock_hold) begin
            lock_act <= 1'b0;
        end
    end
`else
    assign req = m_psel;
`endif

    assign req_any   = |req;
    assign pick      = rr_pick(req, last);
    assign done      = (state == ACCESS) && s_pready;
    assign s_psel    = (state != IDLE);
    assign s_penable = (state == ACCESS);
    assign busy      = (state != IDLE);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_any) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (s_pready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the winner in IDLE. The captured values then stay stable
    // until the downstream transfer completes.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            s_paddr  <= '0;
            s_pwdata <= '0;
            s_pwrite <= 1'b0;
            grant    <= '0;
            gidx     <= '0;
            last     <= LW'(N_M - 1);
        end else if (state == IDLE && req_any) begin
            s_paddr     <= m_paddr[int'(pick)*AW +: AW];
            s_pwdata    <= m_pwdata[int'(pick)*DW +: DW];
            s_pwrite    <= m_pwrite[pick];
            grant       <= '0;
            grant[pick] <= 1'b1;
            gidx        <= pick;
        end else if (done) begin
            grant <= '0;
            last  <= gidx;
        end
    end

    // Route the response to the owner only. If the owner has already dropped
    // psel/penable, the completion is silently discarded.
    always_comb begin
        m_prdata  = '0;
        m_pready  = '0;
        m_pslverr = '0;
        for (int i = 0; i < N_M; i++) begin
            if (grant[i]) begin
                m_prdata[i*DW +: DW] = s_prdata;
                if (done && m_psel[i] && m_penable[i]) begin
                    m_pready[i]  = 1'b1;
                    m_pslverr[i] = s_pslverr;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_apb_arb.sv
module tb_spi_apb_arb;

    localparam int N_M = 2;
    localparam int AW  = 5;
    localparam int DW  = 32;

    logic              pclk = 1'b0;
    logic              presetn;
    logic [N_M*AW-1:0] m_paddr;
    logic [N_M*DW-1:0] m_pwdata;
    logic [N_M-1:0]    m_psel, m_penable, m_pwrite, m_lock;
    logic [N_M*DW-1:0] m_prdata;
    logic [N_M-1:0]    m_pready, m_pslverr;
    logic [AW-1:0]     s_paddr;
    logic [DW-1:0]     s_pwdata;
    logic              s_psel, s_penable, s_pwrite;
    logic [DW-1:0]     s_prdata;
    logic              s_pready, s_pslverr;
    logic [N_M-1:0]    grant;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [N_M-1:0] dut_order[$];

    always #5 pclk = ~pclk;

    spi_apb_arb #(.N_M(N_M), .AW(AW), .DW(DW)) dut (
        .pclk(pclk), .presetn(presetn),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
`ifdef SPI_APB_ARB_LOCK_EN
        .m_lock(m_lock),
`endif
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_psel(s_psel),
        .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        int             m;
        logic           wr;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  rdata;
        int             waits;
        logic           err;
        logic [N_M-1:0] exp_grant;
        logic [N_M-1:0] exp_err;
    } vec_t;

    vec_t tab[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference arbitration rule: first requester after lst, wrapping.
    function automatic int rr_pick(input logic [N_M-1:0] cand, input int lst);
        for (int k = 1; k <= N_M; k++) begin
            if (cand[(lst + k) % N_M]) return (lst + k) % N_M;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        m_paddr = '0; m_pwdata = '0; m_psel = '0; m_penable = '0;
        m_pwrite = '0; m_lock = '0;
        s_prdata = '0; s_pready = 1'b0; s_pslverr = 1'b0;
    endtask

    task automatic do_reset(input bit check);
        presetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge pclk);
        #1;
        if (check) begin
            chk("rst_psel", s_psel, 0);
            chk("rst_penable", s_penable, 0);
            chk("rst_pwrite", s_pwrite, 0);
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_paddr", s_paddr, 0);
            chk("rst_pwdata", s_pwdata, 0);
        end
        presetn = 1'b1;
    endtask

    // One isolated transfer from an idle arbiter, with a fixed number of slave wait states.
    task automatic run_vec(input vec_t v, input int id);
        string tag;
        tag = $sformatf("vec%0d", id);
        @(posedge pclk); #1;
        m_psel[v.m] = 1'b1; m_penable[v.m] = 1'b0; m_pwrite[v.m] = v.wr;
        m_paddr[v.m*AW +: AW] = v.addr; m_pwdata[v.m*DW +: DW] = v.wdata;
        #1;
        chk({tag, "_t0_psel"}, s_psel, 0);
        @(posedge pclk); #1;
        m_penable[v.m] = 1'b1;
        #1;
        chk({tag, "_setup_psel"}, s_psel, 1);
        chk({tag, "_setup_penable"}, s_penable, 0);
        chk({tag, "_grant"}, grant, v.exp_grant);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_paddr"}, s_paddr, v.addr);
        chk({tag, "_pwdata"}, s_pwdata, v.wdata);
        chk({tag, "_pwrite"}, s_pwrite, v.wr);
        for (int w = 0; w <= v.waits; w++) begin
            @(posedge pclk); #1;
            s_pready  = (w == v.waits);
            s_pslverr = (w == v.waits) ? v.err : 1'b0;
            s_prdata  = v.rdata;
            #1;
            chk({tag, "_penable"}, s_penable, 1);
            chk({tag, "_pready"}, m_pready, (w == v.waits) ? v.exp_grant : '0);
            chk({tag, "_pslverr"}, m_pslverr, (w == v.waits) ? v.exp_err : '0);
            if (w == v.waits) chk({tag, "_prdata"}, m_prdata[v.m*DW +: DW], v.rdata);
        end
        @(posedge pclk); #1;
        idle_inputs();
        #1;
        chk({tag, "_end_psel"}, s_psel, 0);
        chk({tag, "_end_grant"}, grant, 0);
    endtask

    // Random traffic against a transaction-level model of the arbitration rules.
    task automatic run_traffic(input int cycles, input int prob, input int maxw, input int lock0_cnt);
        int phase [N_M];
        int issued [N_M];
        logic [AW-1:0] ta [N_M];
        logic [DW-1:0] td [N_M];
        logic          tw [N_M];
        logic [N_M-1:0] prev_psel, prev_lock, done_prev, cand, exp_g, exp_rdy;
        logic prev_sready, prev_dut_psel, mlock, hold, all_idle;
        int busy_m, age, owner, mlast, wt, pk, cyc;
        do_reset(0);
        for (int i = 0; i < N_M; i++) begin
            phase[i] = 0; issued[i] = 0; ta[i] = '0; td[i] = '0; tw[i] = 1'b0;
        end
        prev_psel = '0; prev_lock = '0; done_prev = '0;
        prev_sready = 1'b0; prev_dut_psel = 1'b0; mlock = 1'b0;
        busy_m = 0; age = 0; owner = 0; mlast = N_M - 1; wt = 0; cyc = 0;
        all_idle = 1'b1;
        dut_order.delete();
        while (1'b1) begin
            all_idle = (busy_m == 0);
            for (int i = 0; i < N_M; i++) if (phase[i] != 0) all_idle = 1'b0;
            if (cyc >= cycles && all_idle) break;
            if (cyc >= cycles + 400) break;
            @(posedge pclk); #1;
            // arbiter model
            if (busy_m != 0 && age >= 1 && prev_sready) begin
                busy_m = 0; mlast = owner; mlock = prev_lock[owner];
            end else if (busy_m != 0) begin
                age++;
            end else begin
                hold = mlock && (prev_lock[mlast] || prev_psel[mlast]);
                if (!hold) mlock = 1'b0;
                cand = prev_psel;
                if (hold) begin
                    cand = '0;
                    cand[mlast] = prev_psel[mlast];
                end
                pk = rr_pick(cand, mlast);
                if (pk >= 0) begin
                    busy_m = 1; age = 0; owner = pk;
                end
            end
            // upstream masters
            for (int i = 0; i < N_M; i++) begin
                if (phase[i] == 2 && done_prev[i]) phase[i] = 0;
                else if (phase[i] == 1) phase[i] = 2;
                if (phase[i] == 0 && cyc < cycles && $urandom_range(0, 99) < prob) begin
                    phase[i] = 1;
                    ta[i] = AW'($urandom);
                    td[i] = $urandom;
                    tw[i] = 1'($urandom_range(0, 1));
                    m_lock[i] = (i == 0) && (issued[0] < lock0_cnt);
                    issued[i]++;
                end
                m_psel[i]    = (phase[i] != 0);
                m_penable[i] = (phase[i] == 2);
                m_pwrite[i]  = tw[i];
                m_paddr[i*AW +: AW] = ta[i];
                m_pwdata[i*DW +: DW] = td[i];
            end
            // slave with random wait states
            s_prdata = $urandom;
            if (busy_m != 0 && age >= 1) begin
                if (age == 1) wt = $urandom_range(0, maxw);
                s_pready  = (age - 1 == wt);
                s_pslverr = s_pready & 1'($urandom_range(0, 1));
            end else begin
                s_pready = 1'b0; s_pslverr = 1'b0;
            end
            #1;
            exp_g = '0;
            if (busy_m != 0) exp_g[owner] = 1'b1;
            chk("tr_psel", s_psel, busy_m != 0);
            chk("tr_penable", s_penable, busy_m != 0 && age >= 1);
            chk("tr_busy", busy, busy_m != 0);
            chk("tr_grant", grant, exp_g);
            if (busy_m != 0 && age == 0) begin
                chk("tr_paddr", s_paddr, ta[owner]);
                chk("tr_pwdata", s_pwdata, td[owner]);
                chk("tr_pwrite", s_pwrite, tw[owner]);
            end
            exp_rdy = '0;
            if (busy_m != 0 && age >= 1 && s_pready && phase[owner] == 2) exp_rdy[owner] = 1'b1;
            chk("tr_pready", m_pready, exp_rdy);
            chk("tr_pslverr", m_pslverr, exp_rdy & {N_M{s_pslverr}});
            if (exp_rdy != 0) chk("tr_prdata", m_prdata[owner*DW +: DW], s_prdata);
            if (s_psel && !prev_dut_psel) dut_order.push_back(grant);
            prev_dut_psel = s_psel; prev_psel = m_psel; prev_lock = m_lock;
            prev_sready = s_pready; done_prev = exp_rdy;
            cyc++;
        end
        chk("tr_drain_done", all_idle, 1);
        idle_inputs();
    endtask

    initial begin
        tab[0] = '{0, 1'b1, 5'h04, 32'h0000_00A5, 32'h0,         0, 1'b0, 2'b01, 2'b00};
        tab[1] = '{1, 1'b0, 5'h08, 32'h0,         32'h0000_005A, 3, 1'b0, 2'b10, 2'b00};
        tab[2] = '{0, 1'b1, 5'h1F, 32'hFFFF_FFFF, 32'h0,         1, 1'b1, 2'b01, 2'b01};
        tab[3] = '{1, 1'b1, 5'h00, 32'h0,         32'h1234_5678, 0, 1'b1, 2'b10, 2'b10};
        tab[4] = '{0, 1'b0, 5'h10, 32'h0,         32'hDEAD_BEEF, 2, 1'b0, 2'b01, 2'b00};

        do_reset(1);
        for (int i = 0; i < 5; i++) run_vec(tab[i], i);

        // owner drops psel mid-transfer: downstream completes, response discarded
        @(posedge pclk); #1;
        m_psel[0] = 1'b1; m_paddr[0 +: AW] = 5'h0C;
        @(posedge pclk); #1;
        m_penable[0] = 1'b1;
        @(posedge pclk); #1;
        m_psel[0] = 1'b0; m_penable[0] = 1'b0; s_pready = 1'b1; s_pslverr = 1'b1;
        #1;
        chk("drop_spsel", s_psel, 1);
        chk("drop_pready", m_pready, 0);
        chk("drop_pslverr", m_pslverr, 0);
        @(posedge pclk); #1;
        idle_inputs();
        #1;
        chk("drop_idle", s_psel, 0);

        // reset in ACCESS aborts; the next arbitration restarts from master 0
        do_reset(0);
        run_vec(tab[0], 10);
        @(posedge pclk); #1;
        m_psel[1] = 1'b1;
        @(posedge pclk); #1;
        m_penable[1] = 1'b1;
        @(posedge pclk); #1;
        #1;
        chk("abort_pre_penable", s_penable, 1);
        presetn = 1'b0;
        #1;
        chk("abort_psel", s_psel, 0);
        chk("abort_grant", grant, 0);
        chk("abort_busy", busy, 0);
        idle_inputs();
        @(posedge pclk); #1;
        presetn = 1'b1;
        m_psel = 2'b11;
        @(posedge pclk); #1;
        m_penable = 2'b11;
        #1;
        chk("abort_restart_grant", grant, 2'b01);
        @(posedge pclk); #1;
        s_pready = 1'b1;
        #1;
        chk("abort_restart_pready", m_pready, 2'b01);
        @(posedge pclk); #1;
        idle_inputs();

        // simultaneous requests alternate strictly
        run_traffic(20, 100, 0, 0);
        chk("alt_count_ok", dut_order.size() >= 4, 1);
        for (int k = 0; k < 4 && k < dut_order.size(); k++)
            chk($sformatf("alt_order%0d", k), dut_order[k], (k % 2 == 0) ? 2'b01 : 2'b10);

`ifdef SPI_APB_ARB_LOCK_EN
        // m0 keeps the lock across its first two transfers, drops it on the third
        run_traffic(30, 100, 1, 2);
        chk("lock_count_ok", dut_order.size() >= 4, 1);
        for (int k = 0; k < 4 && k < dut_order.size(); k++)
            chk($sformatf("lock_order%0d", k), dut_order[k], (k < 3) ? 2'b01 : 2'b10);
`endif

        run_traffic(600, 40, 3, 0);
        run_traffic(300, 90, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
